// File: rtl/uart_rx_fifo_ctrl_if.sv
// Host-side byte stream of the UART RX FIFO controller.
// Valid/ready handshake; master drives data and valid.
interface uart_rx_fifo_ctrl_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_fifo_ctrl.sv
// UART RX path: pushes bytes into the FIFO, counts errors, drains to host.
// Define UART_RX_DROP_FERR_EN to keep frame-error bytes out of the FIFO.
module uart_rx_fifo_ctrl #(
  parameter int WATERMARK = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_frame_err,
  output logic             fifo_wr_en,
  output logic [7:0]       fifo_d_in,
  output logic             fifo_rd_en,
  input  logic [7:0]       fifo_d_out,
  input  logic             fifo_empty,
  input  logic             fifo_full,
  uart_rx_fifo_ctrl_if.master host,
  input  logic             clear_status,
  output logic             overrun,
  output logic [CNT_W-1:0] overrun_cnt,
  output logic [CNT_W-1:0] ferr_cnt,
  output logic [4:0]       level,
  output logic             irq_wm
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    CAP,
    OUT
  } state_t;

  state_t     state;
  logic       rd_q;
  logic       m_valid_q;
  logic [7:0] m_data_q;
  logic       drop_ferr;
  logic       ovr_ev;
  logic       ferr_ev;

`ifdef UART_RX_DROP_FERR_EN
  assign drop_ferr = rx_frame_err;
`else
  assign drop_ferr = 1'b0;
`endif

  assign fifo_wr_en = rx_valid & ~fifo_full & ~drop_ferr;
  assign fifo_d_in  = rx_data;
  assign fifo_rd_en = rd_q;
  assign ovr_ev     = rx_valid & fifo_full;
  assign ferr_ev    = rx_valid & rx_frame_err;

  assign host.m_data  = m_data_q;
  assign host.m_valid = m_valid_q;

  // fifo_empty is high when data is available
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rd_q      <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'h00;
    end else begin
      rd_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fifo_empty) begin
            state <= RD;
            rd_q  <= 1'b1;
          end
        end
        RD: state <= CAP;
        CAP: begin
          m_data_q  <= fifo_d_out;
          m_valid_q <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (host.m_ready) begin
            m_valid_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level <= 5'd0;
    end else begin
      unique case ({fifo_wr_en, fifo_rd_en})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
    end
  end

  assign irq_wm = (level >= 5'(WATERMARK));

  // a same-cycle event beats clear_status
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun     <= 1'b0;
      overrun_cnt <= '0;
      ferr_cnt    <= '0;
    end else begin
      if (ovr_ev) begin
        overrun <= 1'b1;
      end else if (clear_status) begin
        overrun <= 1'b0;
      end

      if (clear_status) begin
        overrun_cnt <= {{(CNT_W-1){1'b0}}, ovr_ev};
      end else if (ovr_ev && !(&overrun_cnt)) begin
        overrun_cnt <= overrun_cnt + 1'b1;
      end

      if (clear_status) begin
        ferr_cnt <= {{(CNT_W-1){1'b0}}, ferr_ev};
      end else if (ferr_ev && !(&ferr_cnt)) begin
        ferr_cnt <= ferr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Bench for uart_rx_fifo_ctrl with a 15-entry FIFO model,
// a byte scoreboard and status-counter models.
module tb_uart_rx_fifo_ctrl;

`ifdef UART_RX_DROP_FERR_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif
  localparam int CW = 2;
  localparam int WM = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_frame_err = 1'b0;
  logic          fifo_wr_en;
  logic [7:0]    fifo_d_in;
  logic          fifo_rd_en;
  logic [7:0]    fifo_d_out = 8'h00;
  logic          fifo_empty;
  logic          fifo_full;
  logic          clear_status = 1'b0;
  logic          overrun;
  logic [CW-1:0] overrun_cnt;
  logic [CW-1:0] ferr_cnt;
  logic [4:0]    level;
  logic          irq_wm;

  uart_rx_fifo_ctrl_if hif ();

  uart_rx_fifo_ctrl #(
    .WATERMARK(WM),
    .CNT_W    (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_d_in   (fifo_d_in),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_d_out  (fifo_d_out),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .host        (hif),
    .clear_status(clear_status),
    .overrun     (overrun),
    .overrun_cnt (overrun_cnt),
    .ferr_cnt    (ferr_cnt),
    .level       (level),
    .irq_wm      (irq_wm)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // FIFO model: 15 bytes, registered read data
  logic [7:0] mem [16];
  logic [3:0] wp = 4'd0;
  logic [3:0] rp = 4'd0;
  logic [4:0] cnt = 5'd0;

  assign fifo_full  = (cnt == 5'd15);
  assign fifo_empty = (cnt != 5'd0);

  always @(posedge clk) begin
    if (reset) begin
      wp  <= 4'd0;
      rp  <= 4'd0;
      cnt <= 5'd0;
    end else begin
      if (fifo_wr_en) begin
        mem[wp] <= fifo_d_in;
        wp      <= wp + 4'd1;
      end
      if (fifo_rd_en) begin
        fifo_d_out <= mem[rp];
        rp         <= rp + 4'd1;
      end
      cnt <= cnt + 5'(fifo_wr_en) - 5'(fifo_rd_en);
    end
  end

  // monitor and scoreboard
  logic [7:0]    sb [$];
  logic          e_ovr = 1'b0;
  logic [CW-1:0] e_ocnt = '0;
  logic [CW-1:0] e_fcnt = '0;
  logic          hold_v = 1'b0;
  logic [7:0]    hold_d = 8'h00;
  logic [7:0]    last_d = 8'h00;
  logic [7:0]    exp_b;
  logic          ew, eo, ef;
  int            delivered = 0;

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      e_ovr  = 1'b0;
      e_ocnt = '0;
      e_fcnt = '0;
      hold_v = 1'b0;
    end else begin
      ew = rx_valid & ~fifo_full & ~(DROP & rx_frame_err);
      chk("wr_en", 32'(fifo_wr_en), 32'(ew));
      chk("d_in", 32'(fifo_d_in), 32'(rx_data));
      chk("level", 32'(level), 32'(cnt));
      chk("level_range", 32'(level <= 5'd15), 32'd1);
      chk("irq_wm", 32'(irq_wm), 32'(cnt >= 5'(WM)));
      chk("overrun", 32'(overrun), 32'(e_ovr));
      chk("overrun_cnt", 32'(overrun_cnt), 32'(e_ocnt));
      chk("ferr_cnt", 32'(ferr_cnt), 32'(e_fcnt));
      if (hold_v) begin
        chk("hold_valid", 32'(hif.m_valid), 32'd1);
        chk("hold_data", 32'(hif.m_data), 32'(hold_d));
      end
      if (hif.m_valid && hif.m_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL m_data: got unexpected byte %0h", hif.m_data);
        end else begin
          exp_b = sb.pop_front();
          if (hif.m_data !== exp_b) begin
            errors++;
            $display("FAIL m_data: got %0h expected %0h",
                     hif.m_data, exp_b);
          end
        end
        delivered++;
        last_d = hif.m_data;
      end
      if (ew) sb.push_back(rx_data);
      hold_v = hif.m_valid & ~hif.m_ready;
      hold_d = hif.m_data;
      eo = rx_valid & fifo_full;
      ef = rx_valid & rx_frame_err;
      if (clear_status) begin
        e_ovr  = 1'b0;
        e_ocnt = '0;
        e_fcnt = '0;
      end
      if (eo) begin
        e_ovr = 1'b1;
        if (!(&e_ocnt)) e_ocnt = e_ocnt + 1'b1;
      end
      if (ef && !(&e_fcnt)) e_fcnt = e_fcnt + 1'b1;
    end
  end

  typedef struct {
    logic       rv;
    logic [7:0] d;
    logic       mr;
    logic       e_wr;
    logic       e_rd;
    logic       e_mv;
    logic [7:0] e_md;
    logic [4:0] e_lvl;
  } vec_t;

  vec_t vt [6];
  logic [7:0] fill_d = 8'h00;

  task automatic fill_full();
    int g = 0;
    while (!fifo_full && g < 40) begin
      rx_valid = 1'b1;
      rx_data  = fill_d;
      fill_d   = fill_d + 8'd1;
      step();
      g++;
    end
    rx_valid = 1'b0;
    chk("fill_full", 32'(fifo_full), 32'd1);
  endtask

  task automatic drain();
    int g = 0;
    hif.m_ready = 1'b1;
    while ((sb.size() != 0 || cnt != 5'd0) && g < 300) begin
      step();
      g++;
    end
    repeat (2) step();
    chk("drain_sb", 32'(sb.size()), 32'd0);
    chk("drain_valid", 32'(hif.m_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int g;
    hif.m_ready = 1'b0;

    vt[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0};
    vt[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1};
    vt[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 5'd1};
    vt[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0};
    vt[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd0};
    vt[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0};

    // reset values
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", 32'(hif.m_valid), 32'd0);
    chk("rst_m_data", 32'(hif.m_data), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_irq", 32'(irq_wm), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_ocnt", 32'(overrun_cnt), 32'd0);
    chk("rst_fcnt", 32'(ferr_cnt), 32'd0);
    step();
    hif.m_ready = 1'b1;
    step();
    hif.m_ready = 1'b0;
    @(negedge clk);
    chk("stray_ready_valid", 32'(hif.m_valid), 32'd0);
    chk("stray_ready_rd", 32'(fifo_rd_en), 32'd0);
    step();

    // single byte, table driven
    for (int i = 0; i < 6; i++) begin
      rx_valid    = vt[i].rv;
      rx_data     = vt[i].d;
      hif.m_ready = vt[i].mr;
      @(negedge clk);
      chk($sformatf("vec%0d_wr", i), 32'(fifo_wr_en), 32'(vt[i].e_wr));
      chk($sformatf("vec%0d_rd", i), 32'(fifo_rd_en), 32'(vt[i].e_rd));
      chk($sformatf("vec%0d_mv", i), 32'(hif.m_valid), 32'(vt[i].e_mv));
      chk($sformatf("vec%0d_lvl", i), 32'(level), 32'(vt[i].e_lvl));
      if (vt[i].e_mv)
        chk($sformatf("vec%0d_md", i), 32'(hif.m_data),
            32'(vt[i].e_md));
      step();
    end

    // frame error
    d0 = delivered;
    rx_valid     = 1'b1;
    rx_data      = 8'h3C;
    rx_frame_err = 1'b1;
    step();
    rx_valid     = 1'b0;
    rx_frame_err = 1'b0;
    repeat (8) step();
    @(negedge clk);
    chk("ferr_cnt_one", 32'(ferr_cnt), 32'd1);
    chk("ferr_delivered", 32'(delivered - d0), DROP ? 32'd0 : 32'd1);
    chk("ferr_last", 32'(last_d), DROP ? 32'hA5 : 32'h3C);
    chk("ferr_level", 32'(level), 32'd0);
    step();

    // overrun: fill with m_ready low, then two drops
    hif.m_ready = 1'b0;
    fill_d = 8'h00;
    fill_full();
    chk("full_irq", 32'(irq_wm), 32'd1);
    rx_valid = 1'b1;
    rx_data  = 8'hEE;
    step();
    rx_data  = 8'hEF;
    step();
    rx_valid = 1'b0;
    @(negedge clk);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_cnt_two", 32'(overrun_cnt), 32'd2);
    chk("ovr_level", 32'(level), 32'd15);
    step();
    drain();

    // clear in the same cycle as an overrun, then saturate
    hif.m_ready = 1'b0;
    fill_full();
    rx_valid     = 1'b1;
    rx_data      = 8'h77;
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    rx_valid     = 1'b0;
    @(negedge clk);
    chk("clr_evt_flag", 32'(overrun), 32'd1);
    chk("clr_evt_cnt", 32'(overrun_cnt), 32'd1);
    step();
    rx_valid = 1'b1;
    repeat (4) step();
    rx_valid = 1'b0;
    @(negedge clk);
    chk("ovr_saturate", 32'(overrun_cnt), 32'd3);
    step();
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    @(negedge clk);
    chk("clr_flag", 32'(overrun), 32'd0);
    chk("clr_cnt", 32'(overrun_cnt), 32'd0);
    step();
    drain();

    // random backpressure over 40 bytes
    d0 = delivered;
    for (int i = 0; i < 40; i++) begin
      rx_valid    = 1'b1;
      rx_data     = 8'($urandom);
      hif.m_ready = 1'($urandom_range(0, 1));
      step();
      rx_valid = 1'b0;
      repeat ($urandom_range(2, 6)) begin
        hif.m_ready = 1'($urandom_range(0, 1));
        step();
      end
    end
    drain();
    chk("bp_count", 32'(delivered - d0), 32'd40);

    // reset while a byte waits in OUT
    hif.m_ready = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h11;
    step();
    rx_data  = 8'h22;
    step();
    rx_valid = 1'b0;
    g = 0;
    while (!hif.m_valid && g < 20) begin
      step();
      g++;
    end
    chk("mid_valid", 32'(hif.m_valid), 32'd1);
    chk("mid_level", 32'(level), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(hif.m_valid), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    step();
    hif.m_ready = 1'b1;
    repeat (6) step();
    chk("mid_rst_quiet", 32'(hif.m_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
